// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch, decode and execute stages.
// Instruction word layout: opcode[15:12] dest[11:9] src1[8:6] src2[5:3] imm[2:0].
package pipe_pkg;

  localparam int IW = 16;
  localparam int AW = 8;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int DEST_HI = 11;
  localparam int DEST_LO = 9;
  localparam int SRC1_HI = 8;
  localparam int SRC1_LO = 6;
  localparam int SRC2_HI = 5;
  localparam int SRC2_LO = 3;
  localparam int IMM_HI  = 2;
  localparam int IMM_LO  = 0;

  localparam logic [3:0] ADD  = 4'b0001;
  localparam logic [3:0] SUB  = 4'b0010;
  localparam logic [3:0] AND  = 4'b0011;
  localparam logic [3:0] LOAD = 4'b0100;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [2:0] imm;
  } instr_t;

  function automatic logic [3:0] get_opcode(input logic [IW-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [2:0] get_dest(input logic [IW-1:0] instr);
    return instr[DEST_HI:DEST_LO];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush, occupancy count and a
// head-data view that reads zero while empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         valid_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign valid_o   = (count_q != CW'(0));
  assign do_push_s = push_i && !flush_i;
  assign do_pop_s  = pop_i && valid_o && !flush_i;

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; a full-queue push lands in the slot being popped, which
  // is safe because the head is read before the edge.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: PC, credit-based issue to a 1-cycle synchronous
// instruction memory, prefetch queue toward decode, and redirect flush.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = pipe_pkg::AW,
  parameter int IW    = pipe_pkg::IW
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [IW-1:0] id_instr,
  output logic [AW-1:0] id_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    count_s;
  logic [CW:0]      credit_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;
  logic [AW+IW-1:0] head_s;

  assign pop_s = head_valid_s && id_ready;

  // Entries committed after this cycle, counting the response still on its way.
  assign credit_s = {1'b0, count_s} + (CW+1)'(inflight_q) - (CW+1)'(pop_s);

  // Held low during reset so the memory sees no request while state is cleared.
  assign issue_s = reset && !redirect_valid && (credit_s < (CW+1)'(DEPTH));

  // A response arriving in a redirect cycle belongs to the old stream.
  assign push_s = inflight_q && !redirect_valid;

  // PC, request tag and in-flight flag next-state.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue_s;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue_s) begin
      pc_d  = pc_q + AW'(1);
      tag_d = pc_q;
    end else begin
      pc_d  = pc_q;
      tag_d = tag_q;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + IW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (redirect_valid),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({tag_q, imem_rdata}),
    .rdata_o (head_s),
    .count_o (count_s),
    .valid_o (head_valid_s)
  );

  assign imem_req  = issue_s;
  assign imem_addr = pc_q;
  assign id_valid  = head_valid_s;
  assign id_pc     = head_s[AW+IW-1:IW];
  assign id_instr  = head_s[IW-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench: the expected decode stream is the program order of
// imem starting at the last reset/redirect PC; a negedge monitor checks it.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;

  instr_fetch_queue #(.DEPTH(4), .AW(8), .IW(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  logic [15:0] imem [256];
  logic [23:0] exp_q[$];
  logic [7:0]  exp_nxt;
  logic [7:0]  req_next;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          first_req, first_valid, n_req, n_pop;
  int          rel, r;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous instruction memory: data one cycle after the address.
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // New program stream starting at pc (reset or redirect).
  task automatic restart(input logic [7:0] pc);
    exp_q.delete();
    exp_nxt     = pc;
    req_next    = pc;
    first_req   = -1;
    first_valid = -1;
    n_req       = 0;
    n_pop       = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("rst_pc", {24'd0, id_pc}, 32'd0);
      chk("rst_instr", {16'd0, id_instr}, 32'd0);
    end else if (redirect_valid) begin
      chk("redir_req", {31'd0, imem_req}, 32'd0);
    end else begin
      if (imem_req) begin
        if (first_req < 0) first_req = cyc;
        n_req++;
        chk("imem_addr", {24'd0, imem_addr}, {24'd0, req_next});
        req_next = req_next + 8'd1;
      end
      if (id_valid) begin
        if (first_valid < 0) first_valid = cyc;
        while (exp_q.size() < 4) begin
          exp_q.push_back({exp_nxt, imem[exp_nxt]});
          exp_nxt = exp_nxt + 8'd1;
        end
        chk("id_pc", {24'd0, id_pc}, {24'd0, exp_q[0][23:16]});
        chk("id_instr", {16'd0, id_instr}, {16'd0, exp_q[0][15:0]});
        if (id_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'd0;
    id_ready = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h1298;
    imem[1] = 16'h2970;
    imem[2] = 16'h3E60;
    imem[3] = 16'h4C05;
    restart(8'd0);
    repeat (2) step();

    // Streaming from reset.
    id_ready = 1'b1;
    reset = 1'b1;
    rel = cyc;
    repeat (10) step();
    chk("t1_first_req", first_req, rel);
    chk("t1_latency", first_valid - first_req, 32'd2);
    chk("t1_n_pop", n_pop, 32'd8);
    chk("t1_n_req", n_req, 32'd10);

    // Stall from the start, then release.
    reset = 1'b0;
    id_ready = 1'b0;
    restart(8'd0);
    step();
    reset = 1'b1;
    repeat (8) step();
    chk("t2_n_req", n_req, 32'd4);
    chk("t2_valid", {31'd0, id_valid}, 32'd1);
    chk("t2_head", {16'd0, id_instr}, 32'h1298);
    chk("t2_stall_req", {31'd0, imem_req}, 32'd0);
    id_ready = 1'b1;
    #1;
    chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
    chk("t2_resume_addr", {24'd0, imem_addr}, 32'd4);
    repeat (10) step();

    // Redirect with 3 queued entries and one response in flight.
    reset = 1'b0;
    id_ready = 1'b0;
    restart(8'd0);
    step();
    reset = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    id_ready = 1'b1;
    restart(8'h40);
    r = cyc;
    step();
    redirect_valid = 1'b0;
    chk("t3_flushed", {31'd0, id_valid}, 32'd0);
    repeat (6) step();
    chk("t3_req_lat", first_req - r, 32'd1);
    chk("t3_valid_lat", first_valid - r, 32'd3);

    // Redirect while decode is popping a valid head.
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    restart(8'h80);
    step();
    redirect_valid = 1'b0;
    chk("t4_flushed", {31'd0, id_valid}, 32'd0);
    repeat (5) step();

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    restart(8'h10);
    step();
    redirect_pc = 8'h20;
    restart(8'h20);
    step();
    redirect_valid = 1'b0;
    repeat (6) step();

    // PC wrap.
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    restart(8'hFE);
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    chk("t5_n_pop", n_pop, 32'd6);

    // Reset while two entries are queued.
    id_ready = 1'b0;
    reset = 1'b0;
    restart(8'd0);
    step();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    restart(8'd0);
    #1;
    chk("t6_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    step();
    reset = 1'b1;
    id_ready = 1'b1;
    rel = cyc;
    repeat (6) step();
    chk("t6_first_req", first_req, rel);

    // Randomized traffic.
    repeat (1500) begin
      step();
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 8'($urandom);
        restart(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        restart(8'd0);
      end else begin
        reset = 1'b1;
      end
    end
    redirect_valid = 1'b0;
    reset = 1'b1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
